// File: rtl/econet_hdlc_engine.sv
`default_nettype none
// ============================================================================
//  Module      : econet_hdlc_engine
//  Description : Full-duplex HDLC bit engine for the Econet line: tagged TX/RX
//                byte FIFOs, zero insertion/deletion, flag/abort detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module econet_hdlc_engine #(
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int ABORT_ONES  = 15,
    parameter int RX_WHILE_TX = 0
) (
    input  logic       clock_24m,
    input  logic       nRESET,
    input  logic       econet_clock,
    input  logic       econet_data_in,
    output logic       econet_data_out,
    output logic       econet_drive,
    input  logic       tx_valid,
    input  logic [8:0] tx_data,
    output logic       tx_ready,
    input  logic       tx_abort,
    output logic       rx_valid,
    output logic [8:0] rx_data,
    input  logic       rx_ready,
    output logic       tx_underrun,
    output logic       rx_overrun,
    output logic       rx_abort,
    output logic       rx_error
);

    localparam int c_TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int c_RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int c_AB_W  = $clog2(ABORT_ONES + 1);
    localparam logic [c_AB_W-1:0] c_ABORT_LOAD = c_AB_W'(ABORT_ONES);

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_SEND  = 2'd1;
    localparam logic [1:0] c_TX_ABORT = 2'd2;
    localparam logic [0:0] c_RX_HUNT  = 1'b0;
    localparam logic [0:0] c_RX_RECV  = 1'b1;

    // ------------------------------------------------------------------------
    // Line synchronisers; the Econet clock is only ever sampled
    // ------------------------------------------------------------------------
    logic [2:0] r_clk_s;
    logic [2:0] r_dat_s;
    logic       w_rise;
    logic       w_fall;

    always_ff @(posedge clock_24m or negedge nRESET) begin
        if (!nRESET) begin
            r_clk_s <= 3'b111;
            r_dat_s <= 3'b111;
        end else begin
            r_clk_s <= {r_clk_s[1:0], econet_clock};
            r_dat_s <= {r_dat_s[1:0], econet_data_in};
        end
    end

    assign w_rise = ~r_clk_s[2] & r_clk_s[1];
    assign w_fall = r_clk_s[2] & ~r_clk_s[1];

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [8:0]       r_tx_mem [TX_DEPTH];
    logic [c_TX_AW:0] r_tx_wr;
    logic [c_TX_AW:0] r_tx_rd;
    logic             w_tx_empty;
    logic             w_tx_full;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic [8:0]       w_tx_head;

    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[c_TX_AW-1:0] == r_tx_rd[c_TX_AW-1:0]) &&
                        (r_tx_wr[c_TX_AW] != r_tx_rd[c_TX_AW]);
    assign tx_ready   = ~w_tx_full;
    assign w_tx_push  = tx_valid & ~w_tx_full & ~tx_abort;
    assign w_tx_head  = r_tx_mem[r_tx_rd[c_TX_AW-1:0]];

    always_ff @(posedge clock_24m) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[c_TX_AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clock_24m or negedge nRESET) begin
        if (!nRESET) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else if (tx_abort) begin
            r_tx_rd <= r_tx_wr;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // TX bit engine
    // ------------------------------------------------------------------------
    logic [1:0]        r_tx_state;
    logic [7:0]        r_tx_shift;
    logic              r_tx_raw;
    logic              r_tx_have;
    logic [2:0]        r_tx_bit;
    logic [2:0]        r_tx_ones;
    logic [c_AB_W-1:0] r_tx_acnt;
    logic              r_tx_out;
    logic              r_tx_drive;
    logic              r_tx_underrun;

    // A byte-boundary fall with nothing loaded ends the frame, so SEND never
    // refills on the same cycle as a fall.
    assign w_tx_pop = ~tx_abort & ~w_tx_empty &
                      ((r_tx_state == c_TX_IDLE) |
                       ((r_tx_state == c_TX_SEND) & ~r_tx_have & ~w_fall));

    always_ff @(posedge clock_24m or negedge nRESET) begin
        if (!nRESET) begin
            r_tx_state    <= c_TX_IDLE;
            r_tx_shift    <= 8'h00;
            r_tx_raw      <= 1'b0;
            r_tx_have     <= 1'b0;
            r_tx_bit      <= 3'd0;
            r_tx_ones     <= 3'd0;
            r_tx_acnt     <= '0;
            r_tx_out      <= 1'b1;
            r_tx_drive    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (tx_abort) begin
                r_tx_state <= c_TX_ABORT;
                r_tx_acnt  <= c_ABORT_LOAD;
                r_tx_have  <= 1'b0;
                r_tx_ones  <= 3'd0;
            end else begin
                case (r_tx_state)
                    c_TX_IDLE: begin
                        if (w_tx_pop && w_tx_head[8]) begin
                            r_tx_state <= c_TX_SEND;
                            r_tx_shift <= w_tx_head[7:0];
                            r_tx_raw   <= 1'b1;
                            r_tx_have  <= 1'b1;
                            r_tx_bit   <= 3'd0;
                            r_tx_ones  <= 3'd0;
                        end
                    end
                    c_TX_SEND: begin
                        if (w_fall) begin
                            // Ones only accumulate on data bits, so five of them
                            // always force a zero, even ahead of a closing flag.
                            if (r_tx_ones == 3'd5) begin
                                r_tx_out   <= 1'b0;
                                r_tx_drive <= 1'b1;
                                r_tx_ones  <= 3'd0;
                            end else if (r_tx_have) begin
                                r_tx_out   <= r_tx_shift[r_tx_bit];
                                r_tx_drive <= 1'b1;
                                r_tx_ones  <= (r_tx_raw || !r_tx_shift[r_tx_bit]) ?
                                              3'd0 : r_tx_ones + 3'd1;
                                r_tx_bit   <= r_tx_bit + 3'd1;
                                if (r_tx_bit == 3'd7) r_tx_have <= 1'b0;
                            end else begin
                                r_tx_state    <= c_TX_IDLE;
                                r_tx_out      <= 1'b1;
                                r_tx_drive    <= 1'b0;
                                r_tx_ones     <= 3'd0;
                                r_tx_underrun <= ~r_tx_raw;
                            end
                        end else if (w_tx_pop) begin
                            r_tx_shift <= w_tx_head[7:0];
                            r_tx_raw   <= w_tx_head[8];
                            r_tx_have  <= 1'b1;
                            r_tx_bit   <= 3'd0;
                        end
                    end
                    c_TX_ABORT: begin
                        if (w_fall) begin
                            r_tx_out <= 1'b1;
                            if (r_tx_acnt != '0) begin
                                r_tx_drive <= 1'b1;
                                r_tx_acnt  <= r_tx_acnt - 1'b1;
                            end else begin
                                r_tx_drive <= 1'b0;
                                r_tx_state <= c_TX_IDLE;
                            end
                        end
                    end
                    default: r_tx_state <= c_TX_IDLE;
                endcase
            end
        end
    end

    assign econet_data_out = r_tx_out;
    assign econet_drive    = r_tx_drive;
    assign tx_underrun     = r_tx_underrun;

    // ------------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------------
    logic [8:0]       r_rx_mem [RX_DEPTH];
    logic [c_RX_AW:0] r_rx_wr;
    logic [c_RX_AW:0] r_rx_rd;
    logic             w_rx_empty;
    logic             w_rx_full;
    logic             w_rx_pop;
    logic             w_rx_req;
    logic [8:0]       w_rx_word;
    logic             w_rx_push;
    logic             w_rx_ovf;

    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[c_RX_AW-1:0] == r_rx_rd[c_RX_AW-1:0]) &&
                        (r_rx_wr[c_RX_AW] != r_rx_rd[c_RX_AW]);
    assign rx_valid   = ~w_rx_empty;
    assign rx_data    = r_rx_mem[r_rx_rd[c_RX_AW-1:0]];
    assign w_rx_pop   = rx_valid & rx_ready;
    assign w_rx_push  = w_rx_req & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf   = w_rx_req & w_rx_full & ~w_rx_pop;

    always_ff @(posedge clock_24m) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr[c_RX_AW-1:0]] <= w_rx_word;
        end
    end

    always_ff @(posedge clock_24m or negedge nRESET) begin
        if (!nRESET) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // RX bit engine
    // ------------------------------------------------------------------------
    logic [0:0] r_rx_state;
    logic [2:0] r_rx_ones;
    logic [2:0] r_rx_cnt;
    logic [6:0] r_rx_byte;
    logic       r_rx_overrun;
    logic       r_rx_abort;
    logic       r_rx_error;
    logic       w_rx_bit;
    logic       w_rx_hold;
    logic [2:0] w_rx_ones_inc;

    assign w_rx_bit      = r_dat_s[2];
    assign w_rx_hold     = (RX_WHILE_TX == 0) && r_tx_drive;
    assign w_rx_ones_inc = (r_rx_ones == 3'd7) ? 3'd7 : r_rx_ones + 3'd1;

    always_comb begin
        w_rx_req  = 1'b0;
        w_rx_word = {1'b1, 8'h7E};
        if (w_rise && !w_rx_hold) begin
            if (!w_rx_bit && r_rx_ones == 3'd6) begin
                w_rx_req = 1'b1;
            end else if (r_rx_state == c_RX_RECV && r_rx_ones != 3'd6 &&
                         !(!w_rx_bit && r_rx_ones == 3'd5) && r_rx_cnt == 3'd7) begin
                w_rx_req  = 1'b1;
                w_rx_word = {1'b0, w_rx_bit, r_rx_byte};
            end
        end
    end

    always_ff @(posedge clock_24m or negedge nRESET) begin
        if (!nRESET) begin
            r_rx_state   <= c_RX_HUNT;
            r_rx_ones    <= 3'd7;
            r_rx_cnt     <= 3'd0;
            r_rx_byte    <= 7'd0;
            r_rx_overrun <= 1'b0;
            r_rx_abort   <= 1'b0;
            r_rx_error   <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            r_rx_abort   <= 1'b0;
            r_rx_error   <= 1'b0;
            if (w_rx_hold) begin
                r_rx_state <= c_RX_HUNT;
                r_rx_ones  <= 3'd7;
            end else if (w_rise) begin
                if (r_rx_state == c_RX_HUNT) begin
                    if (w_rx_bit) begin
                        r_rx_ones <= w_rx_ones_inc;
                    end else begin
                        r_rx_ones <= 3'd0;
                        if (r_rx_ones == 3'd6) begin
                            r_rx_state <= c_RX_RECV;
                            r_rx_cnt   <= 3'd0;
                        end
                    end
                end else if (w_rx_bit && r_rx_ones == 3'd6) begin
                    r_rx_abort <= 1'b1;
                    r_rx_state <= c_RX_HUNT;
                    r_rx_ones  <= 3'd7;
                end else if (!w_rx_bit && r_rx_ones == 3'd6) begin
                    // The flag's leading zero and six ones are already shifted
                    // in, so an aligned flag closes with exactly seven bits held.
                    r_rx_error <= (r_rx_cnt != 3'd7);
                    r_rx_cnt   <= 3'd0;
                    r_rx_ones  <= 3'd0;
                end else if (!w_rx_bit && r_rx_ones == 3'd5) begin
                    r_rx_ones <= 3'd0;
                end else begin
                    r_rx_byte <= {w_rx_bit, r_rx_byte[6:1]};
                    r_rx_ones <= w_rx_bit ? w_rx_ones_inc : 3'd0;
                    r_rx_cnt  <= r_rx_cnt + 3'd1;
                end
                if (w_rx_ovf) begin
                    r_rx_overrun <= 1'b1;
                    r_rx_state   <= c_RX_HUNT;
                end
            end
        end
    end

    assign rx_overrun = r_rx_overrun;
    assign rx_abort   = r_rx_abort;
    assign rx_error   = r_rx_error;

endmodule
`default_nettype wire

// File: tb/tb_econet_hdlc_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_econet_hdlc_engine
//  Description : Directed self-checking bench for econet_hdlc_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_econet_hdlc_engine;

    logic       clock_24m = 1'b0;
    logic       nRESET;
    logic       econet_clock;
    logic       econet_data_in;
    logic       econet_data_out;
    logic       econet_drive;
    logic       tx_valid;
    logic [8:0] tx_data;
    logic       tx_ready;
    logic       tx_abort;
    logic       rx_valid;
    logic [8:0] rx_data;
    logic       rx_ready;
    logic       tx_underrun;
    logic       rx_overrun;
    logic       rx_abort;
    logic       rx_error;

    logic        inj_data;
    logic        loop_en;
    logic [63:0] cap_out;
    logic [63:0] cap_drv;
    logic [32:0] exp_t2;
    logic [8:0]  rxq [$];
    int          n_under, n_ovr, n_abt, n_err;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock_24m = ~clock_24m;

    assign econet_data_in = loop_en ? econet_data_out : inj_data;

    econet_hdlc_engine #(
        .TX_DEPTH    (4),
        .RX_DEPTH    (4),
        .ABORT_ONES  (15),
        .RX_WHILE_TX (1)
    ) dut (
        .clock_24m       (clock_24m),
        .nRESET          (nRESET),
        .econet_clock    (econet_clock),
        .econet_data_in  (econet_data_in),
        .econet_data_out (econet_data_out),
        .econet_drive    (econet_drive),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .tx_abort        (tx_abort),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .tx_underrun     (tx_underrun),
        .rx_overrun      (rx_overrun),
        .rx_abort        (rx_abort),
        .rx_error        (rx_error)
    );

    // Popped RX entries and pulse counts, cleared while reset is held
    always @(negedge clock_24m) begin
        if (!nRESET) begin
            rxq.delete();
            n_under = 0; n_ovr = 0; n_abt = 0; n_err = 0;
        end else begin
            if (rx_valid && rx_ready) rxq.push_back(rx_data);
            if (tx_underrun) n_under++;
            if (rx_overrun)  n_ovr++;
            if (rx_abort)    n_abt++;
            if (rx_error)    n_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        nRESET = 1'b0; econet_clock = 1'b1; inj_data = 1'b1; loop_en = 1'b0;
        tx_valid = 1'b0; tx_data = 9'h000; tx_abort = 1'b0; rx_ready = 1'b1;
        repeat (3) @(posedge clock_24m);
        #1 nRESET = 1'b1;
        repeat (4) @(posedge clock_24m);
    endtask

    task automatic push(input logic [8:0] d);
        @(posedge clock_24m); #1;
        tx_valid = 1'b1; tx_data = d;
        @(posedge clock_24m); #1;
        tx_valid = 1'b0;
    endtask

    // One Econet bit period: fall, sample the line late in the low phase, rise
    task automatic bit_cycle(input logic din, output logic dout, output logic drv);
        @(posedge clock_24m); #1;
        inj_data = din; econet_clock = 1'b0;
        repeat (8) @(posedge clock_24m);
        @(negedge clock_24m);
        dout = econet_data_out; drv = econet_drive;
        @(posedge clock_24m); #1;
        econet_clock = 1'b1;
        repeat (8) @(posedge clock_24m);
    endtask

    task automatic run(input int n);
        logic o, d;
        cap_out = '0; cap_drv = '0;
        for (int i = 0; i < n; i++) begin
            bit_cycle(1'b1, o, d);
            cap_out[i] = o; cap_drv[i] = d;
        end
    endtask

    task automatic inj_byte(input logic [7:0] b);
        logic o, d;
        for (int i = 0; i < 8; i++) bit_cycle(b[i], o, d);
    endtask

    task automatic inj_ones(input int n);
        logic o, d;
        for (int i = 0; i < n; i++) bit_cycle(1'b1, o, d);
    endtask

    initial begin
        // Reset state, checked while reset is still asserted
        nRESET = 1'b0; econet_clock = 1'b1; inj_data = 1'b1; loop_en = 1'b0;
        tx_valid = 1'b0; tx_data = 9'h000; tx_abort = 1'b0; rx_ready = 1'b1;
        repeat (2) @(posedge clock_24m);
        @(negedge clock_24m);
        chk("rst_data_out", econet_data_out, 1);
        chk("rst_drive", econet_drive, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_pulses", {tx_underrun, rx_overrun, rx_abort, rx_error}, 0);

        // Flag / 55 / flag, looped back into RX
        do_reset(); loop_en = 1'b1;
        push(9'h17E); push(9'h055); push(9'h17E);
        run(25);
        chk("t1_bits", cap_out[23:0], 24'h7E557E);
        chk("t1_drive", cap_drv[23:0], 24'hFFFFFF);
        chk("t1_end", {cap_drv[24], cap_out[24]}, 2'b01);
        chk("t1_underrun", n_under, 0);
        chk("t1_rx_count", rxq.size(), 3);
        chk("t1_rx0", rxq[0], 9'h17E);
        chk("t1_rx1", rxq[1], 9'h055);
        chk("t1_rx2", rxq[2], 9'h17E);
        chk("t1_rx_error", n_err, 0);

        // Zero insertion carried across a byte boundary
        do_reset(); loop_en = 1'b1;
        push(9'h17E); push(9'h01F); push(9'h000); push(9'h17E);
        run(34);
        exp_t2 = {8'h7E, 8'h00, 9'h01F, 8'h7E};
        chk("t2_bits", cap_out[32:0], exp_t2);
        chk("t2_drive", cap_drv[32:0], 33'h1FFFFFFFF);
        chk("t2_end", {cap_drv[33], cap_out[33]}, 2'b01);
        chk("t2_rx_count", rxq.size(), 4);
        chk("t2_rx0", rxq[0], 9'h17E);
        chk("t2_rx1", rxq[1], 9'h01F);
        chk("t2_rx2", rxq[2], 9'h000);
        chk("t2_rx3", rxq[3], 9'h17E);
        chk("t2_rx_error", n_err, 0);

        // Underrun after a data byte, then a stray data entry is discarded
        do_reset();
        push(9'h17E); push(9'h0AA);
        run(17);
        chk("t3_bits", cap_out[15:0], 16'hAA7E);
        chk("t3_drive", cap_drv[15:0], 16'hFFFF);
        chk("t3_end", {cap_drv[16], cap_out[16]}, 2'b01);
        chk("t3_underrun", n_under, 1);
        push(9'h012);
        run(10);
        chk("t3_discard_drive", cap_drv[9:0], 10'h000);
        chk("t3_discard_out", cap_out[9:0], 10'h3FF);
        chk("t3_tx_ready", tx_ready, 1);
        chk("t3_underrun_once", n_under, 1);

        // RX: flag, 3C, abort by nine ones, then a fresh flag
        do_reset();
        inj_byte(8'h7E); inj_byte(8'h3C); inj_ones(9); inj_byte(8'h7E);
        repeat (4) @(posedge clock_24m);
        chk("t4_rx_count", rxq.size(), 3);
        chk("t4_rx0", rxq[0], 9'h17E);
        chk("t4_rx1", rxq[1], 9'h03C);
        chk("t4_rx2", rxq[2], 9'h17E);
        chk("t4_abort", n_abt, 1);
        chk("t4_error", n_err, 0);

        // RX overrun with the consumer stalled
        do_reset();
        @(posedge clock_24m); #1 rx_ready = 1'b0;
        inj_byte(8'h7E); inj_byte(8'h11); inj_byte(8'h22);
        inj_byte(8'h33); inj_byte(8'h44); inj_byte(8'h55);
        @(negedge clock_24m);
        chk("t5_overrun", n_ovr, 1);
        chk("t5_rx_valid", rx_valid, 1);
        chk("t5_head", rx_data, 9'h17E);
        @(posedge clock_24m); #1 rx_ready = 1'b1;
        repeat (8) @(posedge clock_24m);
        chk("t5_rx_count", rxq.size(), 4);
        chk("t5_rx1", rxq[1], 9'h011);
        chk("t5_rx3", rxq[3], 9'h033);
        inj_byte(8'h7E);
        repeat (4) @(posedge clock_24m);
        chk("t5_rx_count_after", rxq.size(), 5);
        chk("t5_rx4", rxq[4], 9'h17E);

        // Commanded abort mid-frame
        do_reset();
        push(9'h17E); push(9'h055);
        run(3);
        @(posedge clock_24m); #1 tx_abort = 1'b1;
        @(posedge clock_24m); #1 tx_abort = 1'b0;
        run(18);
        chk("t6_abort_drive", cap_drv[17:0], 18'h07FFF);
        chk("t6_abort_out", cap_out[17:0], 18'h3FFFF);
        chk("t6_tx_ready", tx_ready, 1);
        chk("t6_underrun", n_under, 0);

        // Asynchronous reset mid-SEND
        do_reset();
        push(9'h17E); push(9'h055); push(9'h055);
        run(5);
        chk("t7_sending", cap_drv[4:0], 5'h1F);
        @(posedge clock_24m); #3 nRESET = 1'b0;
        #1;
        chk("t7_data_out", econet_data_out, 1);
        chk("t7_drive", econet_drive, 0);
        chk("t7_tx_ready", tx_ready, 1);
        chk("t7_rx_valid", rx_valid, 0);
        repeat (2) @(posedge clock_24m);
        #1 nRESET = 1'b1;
        run(10);
        chk("t7_idle_drive", cap_drv[9:0], 10'h000);
        chk("t7_idle_out", cap_out[9:0], 10'h3FF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
